rx_ds_dec: RTL

Receive-side character decoder for the DS link; the counterpart of the transmit character selector.
- Consumes decoded 9-bit characters from the bit-level receiver and resolves ESC sequences into NULL and time-code events.
- Reports FCTs to the transmitter.
- Tracks the receive credit granted to the far end and forwards N-chars/EOP/EEP to the receive FIFO.
- Raises sticky protocol errors to the link state machine.

---
 rtl/ds_pkg.sv | 30 +++
 rtl/rx_ds_dec_if.sv | 30 +++
 rtl/rx_credit_cnt.sv | 39 +++
 rtl/rx_ds_dec.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared DS link definitions: control codes, special characters, decoder
// state encodings and credit defaults. Also used by the transmit selector.
package ds_pkg;

    localparam int FCT_CREDIT_DEF      = 8;
    localparam int MAX_OUTSTANDING_DEF = 56;

    localparam logic [1:0] CTL_FCT = 2'b00;
    localparam logic [1:0] CTL_EOP = 2'b01;
    localparam logic [1:0] CTL_EEP = 2'b10;
    localparam logic [1:0] CTL_ESC = 2'b11;

    localparam logic [8:0] CHAR_FCT = 9'h100;
    localparam logic [8:0] CHAR_EOP = 9'h101;
    localparam logic [8:0] CHAR_EEP = 9'h102;
    localparam logic [8:0] CHAR_ESC = 9'h103;

    typedef logic [2:0] ds_state_t;

    localparam ds_state_t ST_WAIT_NULL     = 3'd0;
    localparam ds_state_t ST_WAIT_NULL_ESC = 3'd1;
    localparam ds_state_t ST_RUN           = 3'd2;
    localparam ds_state_t ST_RUN_ESC       = 3'd3;
    localparam ds_state_t ST_ERROR         = 3'd4;

    function automatic logic ds_is_code(logic ctl_bit, logic [1:0] low_bits, logic [1:0] code);
        return ctl_bit && (low_bits == code);
    endfunction

endpackage

// File: rtl/rx_ds_dec_if.sv
// Character path of the receive decoder: characters in from the bit-level
// receiver, forwarded characters out to the receive FIFO.
interface rx_ds_dec_if;

    logic       valid_i;
    logic [8:0] dat_i;
    logic       parityErr_i;
    logic       ready_i;
    logic       valid_o;
    logic [8:0] dat_o;

    modport slave (
        input  valid_i,
        input  dat_i,
        input  parityErr_i,
        input  ready_i,
        output valid_o,
        output dat_o
    );

    modport master (
        output valid_i,
        output dat_i,
        output parityErr_i,
        output ready_i,
        input  valid_o,
        input  dat_o
    );

endinterface

// File: rtl/rx_credit_cnt.sv
// Saturating count of receive credit granted to the far end but not yet
// consumed, with a registered "another FCT fits" flag.
module rx_credit_cnt #(
    parameter int FCT_CREDIT      = 8,
    parameter int MAX_OUTSTANDING = 56
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [5:0] outstanding_o,
    output logic       credit_avail_o
);

    logic [5:0] count_q, count_d;
    logic       avail_q, avail_d;
    logic [6:0] sum;

    // Seven bits keep the raw sum unambiguous before clamping at the ceiling.
    always_comb begin
        sum     = {1'b0, count_q} + (inc_i ? 7'(FCT_CREDIT) : 7'd0) - (dec_i ? 7'd1 : 7'd0);
        count_d = (sum > 7'(MAX_OUTSTANDING)) ? 6'(MAX_OUTSTANDING) : sum[5:0];
        avail_d = (count_d <= 6'(MAX_OUTSTANDING - FCT_CREDIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            avail_q <= 1'b1;
        end else begin
            count_q <= count_d;
            avail_q <= avail_d;
        end
    end

    assign outstanding_o  = count_q;
    assign credit_avail_o = avail_q;

endmodule

// File: rtl/rx_ds_dec.sv
// Receive-side DS character decoder: resolves ESC sequences into NULL and
// time-code events, reports FCTs, forwards N-chars and flags protocol errors.
module rx_ds_dec
    import ds_pkg::*;
#(
    parameter int FCT_CREDIT      = FCT_CREDIT_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic             rxClk,
    input  logic             rxReset_n,
    rx_ds_dec_if.slave       bus,
    input  logic             fctSent_i,
    output logic             tick_o,
    output logic [7:0]       timecode_o,
    output logic             gotNull_o,
    output logic             gotFCT_o,
    output logic             nullSeen_o,
    output logic             creditAvail_o,
    output logic [5:0]       outstanding_o,
    output logic             errEsc_o,
    output logic             errCredit_o,
    output logic             errParity_o,
    output logic             errOverflow_o
);

    ds_state_t  state_q, state_d;
    logic       valid_q, valid_d;
    logic [8:0] dat_q, dat_d;
    logic       tick_q, tick_d;
    logic [7:0] timecode_q, timecode_d;
    logic       got_null_q, got_null_d;
    logic       got_fct_q, got_fct_d;
    logic       null_seen_q, null_seen_d;
    logic       err_esc_q, err_esc_d;
    logic       err_credit_q, err_credit_d;
    logic       err_parity_q, err_parity_d;
    logic       err_overflow_q, err_overflow_d;

    logic       fwd;
    logic       credit_inc;
    logic       is_esc, is_fct;
    logic [5:0] outstanding;

    assign is_esc     = ds_is_code(bus.dat_i[8], bus.dat_i[1:0], CTL_ESC);
    assign is_fct     = ds_is_code(bus.dat_i[8], bus.dat_i[1:0], CTL_FCT);
    assign credit_inc = fctSent_i && (state_q != ST_ERROR);

    rx_credit_cnt #(
        .FCT_CREDIT      (FCT_CREDIT),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk            (rxClk),
        .rst_n          (rxReset_n),
        .inc_i          (credit_inc),
        .dec_i          (fwd),
        .outstanding_o  (outstanding),
        .credit_avail_o (creditAvail_o)
    );

    // Parity failures win over any character meaning; ERROR absorbs everything.
    always_comb begin
        state_d        = state_q;
        valid_d        = 1'b0;
        dat_d          = dat_q;
        tick_d         = 1'b0;
        timecode_d     = timecode_q;
        got_null_d     = 1'b0;
        got_fct_d      = 1'b0;
        null_seen_d    = null_seen_q;
        err_esc_d      = err_esc_q;
        err_credit_d   = err_credit_q;
        err_parity_d   = err_parity_q;
        err_overflow_d = err_overflow_q;
        fwd            = 1'b0;

        if (bus.valid_i && (state_q != ST_ERROR)) begin
            if (bus.parityErr_i) begin
                err_parity_d = 1'b1;
                state_d      = ST_ERROR;
            end else begin
                case (state_q)
                    ST_WAIT_NULL: begin
                        if (is_esc) state_d = ST_WAIT_NULL_ESC;
                    end
                    ST_WAIT_NULL_ESC: begin
                        if (is_fct) begin
                            got_null_d  = 1'b1;
                            null_seen_d = 1'b1;
                            state_d     = ST_RUN;
                        end else begin
                            state_d = ST_WAIT_NULL;
                        end
                    end
                    ST_RUN: begin
                        if (is_esc) begin
                            state_d = ST_RUN_ESC;
                        end else if (is_fct) begin
                            got_fct_d = 1'b1;
                        end else if (outstanding == 6'd0) begin
                            err_credit_d = 1'b1;
                            state_d      = ST_ERROR;
                        end else if (!bus.ready_i) begin
                            err_overflow_d = 1'b1;
                            state_d        = ST_ERROR;
                        end else begin
                            valid_d = 1'b1;
                            dat_d   = bus.dat_i;
                            fwd     = 1'b1;
                        end
                    end
                    ST_RUN_ESC: begin
                        if (is_fct) begin
                            got_null_d = 1'b1;
                            state_d    = ST_RUN;
                        end else if (!bus.dat_i[8]) begin
                            tick_d     = 1'b1;
                            timecode_d = bus.dat_i[7:0];
                            state_d    = ST_RUN;
                        end else begin
                            err_esc_d = 1'b1;
                            state_d   = ST_ERROR;
                        end
                    end
                    default: state_d = ST_ERROR;
                endcase
            end
        end
    end

    always_ff @(posedge rxClk or negedge rxReset_n) begin
        if (!rxReset_n) begin
            state_q        <= ST_WAIT_NULL;
            valid_q        <= 1'b0;
            dat_q          <= '0;
            tick_q         <= 1'b0;
            timecode_q     <= '0;
            got_null_q     <= 1'b0;
            got_fct_q      <= 1'b0;
            null_seen_q    <= 1'b0;
            err_esc_q      <= 1'b0;
            err_credit_q   <= 1'b0;
            err_parity_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            dat_q          <= dat_d;
            tick_q         <= tick_d;
            timecode_q     <= timecode_d;
            got_null_q     <= got_null_d;
            got_fct_q      <= got_fct_d;
            null_seen_q    <= null_seen_d;
            err_esc_q      <= err_esc_d;
            err_credit_q   <= err_credit_d;
            err_parity_q   <= err_parity_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.dat_o      = dat_q;
    assign tick_o         = tick_q;
    assign timecode_o     = timecode_q;
    assign gotNull_o      = got_null_q;
    assign gotFCT_o       = got_fct_q;
    assign nullSeen_o     = null_seen_q;
    assign outstanding_o  = outstanding;
    assign errEsc_o       = err_esc_q;
    assign errCredit_o    = err_credit_q;
    assign errParity_o    = err_parity_q;
    assign errOverflow_o  = err_overflow_q;

endmodule
